multi_input_conditioner: RTL and testbench
==========================================

# multi_input_conditioner

Parametrised, multi-channel input conditioner for raw asynchronous board inputs (buttons, switches, external pins). Each channel is synchronised, debounced, and edge-detected. Each channel also gets a long-press (hold) detector and optional polarity inversion. The block sits between top-level pins and any logic that needs clean, single-cycle event pulses.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flop depth per channel (2..4).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a new level (≥1).
- `HOLD_CYCLES`, 8: cycles `conditioned` must stay high before `hold` pulses (≥1).
- `INVERT_MASK`, `{CHANNELS{1'b0}}`: bit i = 1 inverts channel i before synchronisation, for active-low pins.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `noisysignal` in CHANNELS: raw asynchronous inputs.
- `conditioned` out CHANNELS: debounced level per channel.
- `positiveedge` out CHANNELS: one-cycle pulse when `conditioned[i]` rises.
- `negativeedge` out CHANNELS: one-cycle pulse when `conditioned[i]` falls.
- `hold` out CHANNELS: one-cycle pulse when `conditioned[i]` has been high for `HOLD_CYCLES` cycles.

## Operation
- Reset (`reset_n`=0, asynchronous): all sync flops, debounce counters, hold counters, `conditioned`, `positiveedge`, `negativeedge` and `hold` are forced to 0. This applies regardless of `INVERT_MASK`.
- Per channel: `raw_i = noisysignal[i] ^ INVERT_MASK[i]`, fed into a `SYNC_STAGES`-deep flop chain. The last stage is `synced_i`.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - If `synced_i == conditioned[i]`, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the values still differ, the next edge loads `conditioned[i] <= synced_i` and clears the counter.
- Any mismatch shorter than `DEBOUNCE_CYCLES` cycles leaves `conditioned` unchanged and restarts the count at the next mismatch.
- Edge outputs are registered and asserted on the same edge that updates `conditioned`:
  - `positiveedge[i]=1` for exactly one cycle on a 0→1 update.
  - `negativeedge[i]=1` for exactly one cycle on a 1→0 update.
  - Both are never high together.
- Hold counter, width `$clog2(HOLD_CYCLES+1)`:
  - Cleared while `conditioned[i]=0`.
  - Increments each cycle while `conditioned[i]=1`, and saturates at `HOLD_CYCLES`.
  - `hold[i]` pulses for one cycle on the edge at which the counter reaches `HOLD_CYCLES`.
  - One `hold` pulse per press; it does not repeat.
  - A fall before saturation produces no pulse.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses with no arbitration.

## Timing
- `noisysignal` changes between edges. Edge 1 samples it into sync stage 0. `synced_i` reflects it after `SYNC_STAGES` edges.
- `conditioned` and the matching edge pulse update at edge `SYNC_STAGES + DEBOUNCE_CYCLES` after the input change, counting the first sampling edge as 1. With the defaults this is edge 6, and the outputs are valid just after that edge.
- Edge pulse width: exactly 1 clock.
- `hold` asserts `HOLD_CYCLES` edges after the `conditioned` rise edge. With the default of 8, that is edge 14 from the input change.
- Input glitches narrower than `DEBOUNCE_CYCLES` clock periods after synchronisation never reach `conditioned`.
- Reset mid-debounce or mid-hold discards the partial count. After `reset_n` deasserts, an input already high (after inversion) takes the full `SYNC_STAGES + DEBOUNCE_CYCLES` latency and then generates a `positiveedge`.
- `DEBOUNCE_CYCLES=1`: `conditioned` follows `synced` with one extra cycle of latency.

## Structure
- Shared package `conditioner_pkg`: a localparam function for counter width (`$clog2(N+1)`) and the default parameter values.
- Sub-module `input_conditioner_channel`:
  - Holds one channel's sync chain, debounce counter, edge registers and hold counter.
  - Takes scalar `invert` plus `SYNC_STAGES`, `DEBOUNCE_CYCLES` and `HOLD_CYCLES` parameters.
  - The top level instantiates it `CHANNELS` times in a generate loop and concatenates the outputs.

## Test plan
Defaults unless stated; clk period 20 ns.
- **Sync/debounce latency:** ch0 0→1 at t=120 ns → `conditioned[0]` stays 0 through 5 edges, is 1 just after edge 6, and `positiveedge[0]` is 1 for exactly that cycle.
- **Glitch rejection:** ch1 stable 1, then toggle every 7 ns for 10 toggles → `conditioned[1]` remains 1 and `negativeedge[1]` stays 0 throughout.
- **Falling edge:** ch0 1→0 → `negativeedge[0]` is 0 for 5 edges, 1 after edge 6, 0 again 20 ns later, and `conditioned[0]` is 0.
- **Hold:**
  - ch2 held high: `positiveedge[2]` at edge 6, a single `hold[2]` pulse at edge 14, and no further `hold` pulse.
  - A second press of only 5 cycles after `conditioned` rises → no `hold`.
- **Inversion and multi-channel:**
  - Setup: `INVERT_MASK=4'b1000`; ch3 pin driven 1→0 while ch0 is driven 0→1 on the same cycle.
  - Required: `conditioned[3]` and `conditioned[0]` both rise at edge 6, with simultaneous `positiveedge[3]` and `positiveedge[0]`.
- **Async reset mid-operation:** assert `reset_n`=0 between edges at edge 4 of a debounce → all outputs 0 immediately. Release with the pin still high → `positiveedge` 6 edges after release.

Source files
------------

// File: rtl/conditioner_pkg.sv
// Shared parameters and helpers for the multi-channel input conditioner.
// Holds the default parameter values and the counter width function.
package conditioner_pkg;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES     = 8;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioner channel: optional inversion, synchroniser, debouncer,
// edge detector and long-press (hold) detector.
//   clk, reset_n : clock, async active-low reset
//   invert       : 1 inverts the raw pin before synchronisation
//   noisysignal  : raw asynchronous pin
//   conditioned  : debounced level
//   positiveedge : 1-cycle pulse on a 0->1 update of conditioned
//   negativeedge : 1-cycle pulse on a 1->0 update of conditioned
//   hold         : 1-cycle pulse once conditioned has been high HOLD_CYCLES
module input_conditioner_channel
    import conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic invert,
    input  logic noisysignal,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge,
    output logic hold
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_db_cnt;
    logic [HW-1:0]          r_hold_cnt;
    logic                   r_cond;
    logic                   r_pos;
    logic                   r_neg;
    logic                   r_hold;

    logic w_raw;
    logic w_synced;
    logic w_diff;
    logic w_accept;

    assign w_raw    = noisysignal ^ invert;
    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_synced ^ r_cond;
    // Final cycle of an unbroken mismatch run: take the new level now.
    assign w_accept = w_diff && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt <= '0;
            r_cond   <= 1'b0;
        end else if (!w_diff) begin
            r_db_cnt <= '0;
        end else if (w_accept) begin
            r_db_cnt <= '0;
            r_cond   <= w_synced;
        end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
        end
    end

    // Pulses are registered so they line up with the conditioned update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            r_pos <= w_accept & w_synced;
            r_neg <= w_accept & ~w_synced;
        end
    end

    // Saturating counter gives exactly one hold pulse per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_hold <= r_cond && (r_hold_cnt == HOLD_LAST);
            if (!r_cond) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    assign conditioned  = r_cond;
    assign positiveedge = r_pos;
    assign negativeedge = r_neg;
    assign hold         = r_hold;

endmodule

// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: CHANNELS independent copies of the
// per-channel synchroniser / debouncer / edge / hold logic.
//   clk, reset_n : clock, async active-low reset
//   noisysignal  : raw asynchronous pins, one per channel
//   conditioned  : debounced levels
//   positiveedge : rise pulses
//   negativeedge : fall pulses
//   hold         : long-press pulses
module multi_input_conditioner
    import conditioner_pkg::*;
#(
    parameter int                  CHANNELS        = DEF_CHANNELS,
    parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                  HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [CHANNELS-1:0] INVERT_MASK     = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] hold
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        input_conditioner_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .invert      (INVERT_MASK[g]),
            .noisysignal (noisysignal[g]),
            .conditioned (conditioned[g]),
            .positiveedge(positiveedge[g]),
            .negativeedge(negativeedge[g]),
            .hold        (hold[g])
        );
    end

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Scoreboard bench for multi_input_conditioner.
// History-window reference model, directed scenarios then random pins.
module tb_multi_input_conditioner;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int HL = 8192;
    localparam logic [CH-1:0] MASK = 4'b1000;

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] p;
        logic [CH-1:0] n;
        logic [CH-1:0] h;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] noisysignal;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positiveedge;
    logic [CH-1:0] negativeedge;
    logic [CH-1:0] hold;

    int n_pass  = 0;
    int n_total = 0;

    exp_t sb_q[$];

    bit   raw_h [CH][HL];
    bit   sync_h[CH][HL];
    bit   cond_h[CH][HL];
    int   n_edge;
    logic [CH-1:0] m_cond;

    multi_input_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .INVERT_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisysignal (noisysignal),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .hold        (hold)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, got, exp, $time);
    endtask

    // Reference model. Sync output at edge k is the pin sampled S edges
    // earlier; the level flips once the last D synced samples all differ
    // from it; hold fires when the last H pre-edge levels are all high
    // and the one before them was low.
    always @(posedge clk or negedge reset_n) begin
        exp_t e;
        bit   flip;
        bit   hl;
        int   k;
        if (!reset_n) begin
            n_edge = 0;
            m_cond = '0;
            sb_q.delete();
        end else begin
            e = '0;
            k = n_edge;
            for (int c = 0; c < CH; c++) begin
                raw_h[c][k]  = noisysignal[c] ^ MASK[c];
                sync_h[c][k] = (k >= S) ? raw_h[c][k-S] : 1'b0;
                cond_h[c][k] = m_cond[c];
                flip = (k - D + 1 >= 0);
                for (int j = k - D + 1; j <= k; j++)
                    if (j >= 0 && sync_h[c][j] == m_cond[c]) flip = 0;
                hl = (k >= H) && (cond_h[c][k-H] == 1'b0);
                for (int j = k - H + 1; j <= k; j++)
                    if (j >= 0 && cond_h[c][j] == 1'b0) hl = 0;
                if (flip) begin
                    e.p[c]    = ~m_cond[c];
                    e.n[c]    = m_cond[c];
                    m_cond[c] = ~m_cond[c];
                end
                e.h[c] = hl;
            end
            e.c = m_cond;
            n_edge++;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_outputs",
                {16'h0, conditioned, positiveedge, negativeedge, hold},
                {16'h0, e});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse_check(input string nm);
        reset_n = 1'b0;
        #1;
        chk(nm, {16'h0, conditioned, positiveedge, negativeedge, hold},
            32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        noisysignal = 4'b1000;
        cycles(2);
        reset_n = 1'b1;
        while ($time < 120) @(negedge clk);

        noisysignal[0] = 1'b1;
        cycles(20);

        noisysignal[1] = 1'b1;
        cycles(12);
        #4;
        for (int t = 0; t < 10; t++) begin
            noisysignal[1] = ~noisysignal[1];
            #7;
        end
        cycles(12);

        noisysignal[0] = 1'b0;
        cycles(12);

        noisysignal[2] = 1'b1;
        cycles(20);
        noisysignal[2] = 1'b0;
        cycles(12);
        noisysignal[2] = 1'b1;
        cycles(5);
        noisysignal[2] = 1'b0;
        cycles(20);

        noisysignal[3] = 1'b0;
        noisysignal[0] = 1'b1;
        cycles(20);

        noisysignal[2] = 1'b1;
        repeat (4) @(posedge clk);
        #5;
        reset_pulse_check("reset_mid_debounce");
        @(negedge clk);
        reset_n = 1'b1;
        cycles(20);

        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            if (it == 700) begin
                #2;
                reset_pulse_check("reset_random");
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                #($urandom_range(1, 9));
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 9) == 0)
                        noisysignal[c] = ~noisysignal[c];
            end
        end
        cycles(20);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
